// File: rtl/ir_nec_receiver.sv
// ir_nec_receiver: NEC infrared frame decoder with leader/bit timing checks, timeout and optional repeat codes.
// Ports: clock/reset (sync, active-high), ir_signal (async, idle high, mark low),
// ir_reader_out (last accepted frame, first bit in bit 0), avail (accept/repeat pulse),
// frame_err (abandoned-frame pulse). Define IR_REPEAT_EN to accept NEC repeat codes.
module ir_nec_receiver #(
  parameter int US_DIV = 1,
  parameter bit CHECK_EN = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ir_signal,
  output logic [31:0] ir_reader_out,
  output logic        avail,
  output logic        frame_err
);
  localparam logic [2:0] IDLE = 3'd0, LEAD_MARK = 3'd1, LEAD_SPACE = 3'd2, BIT_MARK = 3'd3,
                         BIT_SPACE = 3'd4, STOP_MARK = 3'd5, RPT_MARK = 3'd6;
  logic s1, s2, s3;
  logic [15:0] div;
  logic [13:0] dur;
  logic [2:0] state;
  logic [5:0] bit_cnt;
  logic [31:0] shift;
  logic tick, fall, rise, timeout, lead_ok, data_sp, rpt_sp, bit_ok, one_ok, check_ok;
`ifdef IR_REPEAT_EN
  logic got_frame;
`endif
  always_comb begin
    tick = div == 16'(US_DIV - 1);
    fall = s3 & ~s2;
    rise = ~s3 & s2;
    timeout = state != IDLE && dur >= 14'd12000;
    lead_ok = dur >= 14'd8000 && dur <= 14'd10000;
    data_sp = dur >= 14'd4000 && dur <= 14'd5000;
    rpt_sp = dur >= 14'd2000 && dur <= 14'd2500;
    bit_ok = dur >= 14'd400 && dur <= 14'd750;
    one_ok = dur >= 14'd1400 && dur <= 14'd1900;
    check_ok = !CHECK_EN || shift[31:24] == ~shift[23:16];
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      {s1, s2, s3} <= '1;
      div <= '0;
      dur <= '0;
      state <= IDLE;
      bit_cnt <= '0;
      shift <= '0;
      ir_reader_out <= '0;
      avail <= 1'b0;
      frame_err <= 1'b0;
`ifdef IR_REPEAT_EN
      got_frame <= 1'b0;
`endif
    end else begin
      s1 <= ir_signal;
      s2 <= s1;
      s3 <= s2;
      div <= tick ? '0 : div + 16'd1;
      dur <= (fall || rise) ? '0 : (tick && dur != '1) ? dur + 14'd1 : dur;
      avail <= 1'b0;
      frame_err <= 1'b0;
      // a timeout wins over any edge arriving in the same cycle
      if (timeout) begin
        frame_err <= 1'b1;
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (fall) state <= LEAD_MARK;
          LEAD_MARK: if (rise) begin
            state <= lead_ok ? LEAD_SPACE : IDLE;
            frame_err <= !lead_ok;
          end
          LEAD_SPACE: if (fall) begin
            bit_cnt <= '0;
            state <= data_sp ? BIT_MARK : rpt_sp ? RPT_MARK : IDLE;
            frame_err <= !data_sp && !rpt_sp;
          end
          BIT_MARK: if (rise) begin
            state <= bit_ok ? BIT_SPACE : IDLE;
            frame_err <= !bit_ok;
          end
          BIT_SPACE: if (fall) begin
            if (bit_ok || one_ok) begin
              shift <= {one_ok, shift[31:1]};
              bit_cnt <= bit_cnt + 6'd1;
              state <= bit_cnt == 6'd31 ? STOP_MARK : BIT_MARK;
            end else begin
              state <= IDLE;
              frame_err <= 1'b1;
            end
          end
          STOP_MARK: if (rise) begin
            state <= IDLE;
            if (bit_ok && check_ok) begin
              ir_reader_out <= shift;
              avail <= 1'b1;
`ifdef IR_REPEAT_EN
              got_frame <= 1'b1;
`endif
            end else begin
              frame_err <= 1'b1;
            end
          end
          RPT_MARK: if (rise) begin
            state <= IDLE;
`ifdef IR_REPEAT_EN
            avail <= bit_ok && got_frame;
            frame_err <= !(bit_ok && got_frame);
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
